// File: rtl/sign_extend_if.sv
// Decode-to-ALU immediate transfer: request side carries the raw immediate, response side the widened value.
// The lui field exists only when SIGNEXT_LUI_EN is defined.
interface sign_extend_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic [IN_W-1:0]  input1;
  logic             signext;
`ifdef SIGNEXT_LUI_EN
  logic             lui;
`endif
  logic             out_valid;
  logic [OUT_W-1:0] output1;

  modport master (
    output in_valid, input1, signext,
`ifdef SIGNEXT_LUI_EN
    output lui,
`endif
    input  out_valid, output1
  );

  modport slave (
    input  in_valid, input1, signext,
`ifdef SIGNEXT_LUI_EN
    input  lui,
`endif
    output out_valid, output1
  );
endinterface

// File: rtl/sign_extend_unit.sv
// Registered IN_W->OUT_W immediate extender (sign or zero per transfer), 1-cycle latency, full throughput.
// Optional feature macro: SIGNEXT_LUI_EN adds a lui request that places the immediate in the upper bits.
module sign_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32  // must be >= IN_W
) (
  input logic            clk,
  input logic            reset,
  sign_extend_if.slave   bus
);
  localparam int PAD = OUT_W - IN_W;

  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] ext_norm;
  logic [OUT_W-1:0] ext_hi;

  generate
    if (PAD == 0) begin : g_nopad
      assign ext_norm = bus.input1;
      assign ext_hi   = bus.input1;
    end else begin : g_pad
      logic fill;
      assign fill     = bus.signext & bus.input1[IN_W-1];
      assign ext_norm = {{PAD{fill}}, bus.input1};
      assign ext_hi   = {bus.input1, {PAD{1'b0}}};
    end
  endgenerate

`ifdef SIGNEXT_LUI_EN
  assign ext = bus.lui ? ext_hi : ext_norm;
`else
  assign ext = ext_norm;
  logic unused_hi;
  assign unused_hi = ^ext_hi;
`endif

  // output1 loads only on valid transfers so idle-cycle garbage never reaches it
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.output1   <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.output1 <= ext;
    end
  end
endmodule

// File: tb/tb_sign_extend_unit.sv
// Directed + randomized bench for sign_extend_unit against an arithmetic reference model.
module tb_sign_extend_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] exp_out = '0;

  always #5 clk = ~clk;

  sign_extend_if #(.IN_W(16), .OUT_W(32)) bus();

  sign_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Value of the extended immediate computed as an integer, not as bit wiring
  function automatic logic [31:0] model(input logic [15:0] x, input logic se, input logic l);
    int unsigned u;
    u = x;
    if (l) return u * 65536;
    if (se && u >= 32768) return u + 32'hFFFF0000;
    return u;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic v,
                      input logic [15:0] x, input logic se, input logic l);
    logic le;
    le = 1'b0;
`ifdef SIGNEXT_LUI_EN
    le = l;
    bus.lui = l;
`endif
    reset        = rst;
    bus.in_valid = v;
    bus.input1   = x;
    bus.signext  = se;
    @(posedge clk);
    #1;
    if (rst)    exp_out = '0;
    else if (v) exp_out = model(x, se, le);
    check({tag, "_valid"}, {31'b0, bus.out_valid}, {31'b0, v & ~rst});
    check({tag, "_data"}, bus.output1, exp_out);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.input1   = '0;
    bus.signext  = 1'b0;
`ifdef SIGNEXT_LUI_EN
    bus.lui      = 1'b0;
`endif
    reset = 1'b1;
    #1;

    step("rst0", 1, 0, 16'h0000, 0, 0);
    step("rst1", 1, 0, 16'h0000, 0, 0);

    step("pos5", 0, 1, 16'h0005, 1, 0);
    step("pos8", 0, 1, 16'h0008, 1, 0);
    step("neg_se", 0, 1, 16'h8000, 1, 0);
    step("neg_ze", 0, 1, 16'h8000, 0, 0);
    step("ones_se", 0, 1, 16'hFFFF, 1, 0);
    step("ones_ze", 0, 1, 16'hFFFF, 0, 0);
    check("lit_ones", bus.output1, 32'h0000FFFF);

    step("rst_pri", 1, 1, 16'hFFFF, 1, 0);
    check("lit_rst", bus.output1, 32'h00000000);

    step("max_pos", 0, 1, 16'h7FFF, 1, 0);
    check("lit_7fff", bus.output1, 32'h00007FFF);
    step("hold0", 0, 0, 16'hAAAA, 1, 0);
    step("hold1", 0, 0, 16'h5555, 0, 0);
    step("hold2", 0, 0, 16'hxxxx, 1, 0);

    step("lit_chk", 0, 1, 16'h8000, 1, 0);
    check("lit_8000", bus.output1, 32'hFFFF8000);

`ifdef SIGNEXT_LUI_EN
    step("lui", 0, 1, 16'h1234, 1, 1);
    check("lit_lui", bus.output1, 32'h12340000);
    step("nolui", 0, 1, 16'h8001, 1, 0);
    check("lit_nolui", bus.output1, 32'hFFFF8001);
`endif

    for (int i = 0; i < 80; i++) begin
      step("rnd", ($urandom_range(0, 15) == 0), $urandom_range(0, 1),
           16'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    reset        = 1'b0;
    bus.in_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
